// File: rtl/hamming_arbiter.sv
// -----------------------------------------------------------------------------
// hamming_arbiter
//
// Two-requester round-robin front end for a shared, externally implemented
// Hamming encoder. One 26-bit word is in flight at a time. The accepted word
// is registered onto enc_data and held stable while the encoder works. After
// ENC_LAT cycles the returned codeword is captured into out_code and held
// until the consumer handshakes it.
//
// Parameters
//   ENC_LAT     encoder latency in cycles from stable enc_data to valid
//               enc_code (legal range 1..15)
//
// Ports
//   clock       single clock, rising-edge active
//   reset       synchronous, active-high
//   req0_*      requester 0 valid/ready/data handshake
//   req1_*      requester 1 valid/ready/data handshake
//   enc_data    registered word driven to the shared encoder
//   enc_code    codeword returned by the shared encoder
//   out_valid   out_code/out_id hold a finished result
//   out_code    captured codeword
//   out_id      index of the requester that owns out_code
//   out_ready   consumer accepts the result when high with out_valid
//   busy        high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module hamming_arbiter #(
  parameter int unsigned ENC_LAT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [25:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [25:0] req1_data,
  output logic        req1_ready,
  output logic [25:0] enc_data,
  input  logic [31:0] enc_code,
  output logic        out_valid,
  output logic [31:0] out_code,
  output logic        out_id,
  input  logic        out_ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENCODE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ENC_LAT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] count;
  logic       last_grant;   // 1 = requester 1 was granted last
  logic       grant0;
  logic       grant1;
  logic       accept0;
  logic       accept1;

  // Round robin: a lone valid requester wins; on a tie the requester that
  // was not granted last wins. last_grant resets to 1 so requester 0 takes
  // the first tie.
  assign grant0 = req0_valid && (!req1_valid || last_grant);
  assign grant1 = req1_valid && (!req0_valid || !last_grant);

  // Ready is gated by reset so nothing can appear accepted in a reset cycle.
  assign req0_ready = (state == IDLE) && !reset && grant0;
  assign req1_ready = (state == IDLE) && !reset && grant1;

  assign accept0 = req0_valid && req0_ready;
  assign accept1 = req1_valid && req1_ready;

  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: state_nxt gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept0 || accept1) state_nxt = ENCODE;
      ENCODE:  if (count == 4'd0)      state_nxt = HOLD;
      HOLD:    if (out_ready)          state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  // Datapath. Reset wins over any handshake in the same cycle, so an
  // in-flight word is simply dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      enc_data   <= '0;
      out_code   <= '0;
      out_id     <= 1'b0;
      count      <= '0;
      last_grant <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept0) begin
            enc_data   <= req0_data;
            out_id     <= 1'b0;
            last_grant <= 1'b0;
            count      <= CNT_LOAD;
          end else if (accept1) begin
            enc_data   <= req1_data;
            out_id     <= 1'b1;
            last_grant <= 1'b1;
            count      <= CNT_LOAD;
          end
        end
        ENCODE: begin
          // count == 0 marks the last encoder cycle: enc_data has now been
          // stable for ENC_LAT cycles, so enc_code is valid.
          if (count == 4'd0) begin
            out_code <= enc_code;
          end else begin
            count <= count - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_arbiter.sv
// -----------------------------------------------------------------------------
// tb_hamming_arbiter
//
// Three copies of hamming_arbiter (ENC_LAT = 1, 3, 4) share one stimulus
// stream. Each copy drives its own behavioural encoder: enc_data delayed by
// ENC_LAT-1 registers and then Hamming(31,26)+overall parity encoded, so a
// copy that captures early picks up a stale codeword. A transaction-level
// reference model (accept cycle + latency arithmetic) predicts every output
// of every copy each cycle.
// -----------------------------------------------------------------------------
module tb_hamming_arbiter;

  logic        clock;
  logic        reset;
  logic        req0_valid;
  logic [25:0] req0_data;
  logic        req1_valid;
  logic [25:0] req1_data;
  logic        out_ready;

  logic        r0_rdy [3];
  logic        r1_rdy [3];
  logic [25:0] ed     [3];
  logic [31:0] ec     [3];
  logic        ov     [3];
  logic [31:0] oc     [3];
  logic        oid    [3];
  logic        bsy    [3];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state, one entry per copy.
  bit          m_busy [3];
  int          m_acc  [3];
  logic [25:0] m_data [3];
  bit          m_id   [3];
  logic [31:0] m_code [3];
  bit          m_last [3];
  bit          e_r0   [3];
  bit          e_r1   [3];
  bit          e_ov   [3];
  int          acc_seen [3];
  bit          ov_prev  [3];
  bit          id_log [$];

  logic [25:0] dl1 [2];
  logic [25:0] dl2 [3];

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 3 : 4;
  endfunction

  // Hamming(31,26): code[1..31] by position, parity bits at powers of two,
  // data bits fill the rest in ascending order; code[0] is overall parity.
  function automatic logic [31:0] ham(input logic [25:0] d);
    logic [31:0] c;
    int          j;
    bit          par;
    c = '0;
    j = 0;
    for (int p = 1; p < 32; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p] = d[j];
        j++;
      end
    end
    for (int b = 0; b < 5; b++) begin
      par = 1'b0;
      for (int p = 1; p < 32; p++) begin
        if ((p & (1 << b)) != 0) par = par ^ c[p];
      end
      c[1 << b] = par;
    end
    c[0] = ^c[31:1];
    return c;
  endfunction

  hamming_arbiter #(.ENC_LAT(1)) u_lat1 (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(r0_rdy[0]),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(r1_rdy[0]),
    .enc_data(ed[0]), .enc_code(ec[0]),
    .out_valid(ov[0]), .out_code(oc[0]), .out_id(oid[0]),
    .out_ready(out_ready), .busy(bsy[0])
  );

  hamming_arbiter #(.ENC_LAT(3)) u_lat3 (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(r0_rdy[1]),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(r1_rdy[1]),
    .enc_data(ed[1]), .enc_code(ec[1]),
    .out_valid(ov[1]), .out_code(oc[1]), .out_id(oid[1]),
    .out_ready(out_ready), .busy(bsy[1])
  );

  hamming_arbiter #(.ENC_LAT(4)) u_lat4 (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(r0_rdy[2]),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(r1_rdy[2]),
    .enc_data(ed[2]), .enc_code(ec[2]),
    .out_valid(ov[2]), .out_code(oc[2]), .out_id(oid[2]),
    .out_ready(out_ready), .busy(bsy[2])
  );

  // Behavioural encoders: ENC_LAT-1 delay stages, then combinational encode.
  always @(posedge clock) begin
    dl1[0] <= ed[1];
    dl1[1] <= dl1[0];
    dl2[0] <= ed[2];
    dl2[1] <= dl2[0];
    dl2[2] <= dl2[1];
  end

  always_comb begin
    ec[0] = ham(ed[0]);
    ec[1] = ham(dl1[1]);
    ec[2] = ham(dl2[2]);
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: compare all copies against the model mid-cycle, then
  // advance the model on the rising edge with the same inputs the DUTs saw.
  task automatic tick();
    @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      e_ov[k] = m_busy[k] && (cyc >= m_acc[k] + lat_of(k) + 1);
      e_r0[k] = !reset && !m_busy[k] && req0_valid && (!req1_valid || m_last[k]);
      e_r1[k] = !reset && !m_busy[k] && req1_valid && (!req0_valid || !m_last[k]);
      check($sformatf("lat%0d req0_ready", lat_of(k)), 32'(r0_rdy[k]), 32'(e_r0[k]));
      check($sformatf("lat%0d req1_ready", lat_of(k)), 32'(r1_rdy[k]), 32'(e_r1[k]));
      check($sformatf("lat%0d busy", lat_of(k)),       32'(bsy[k]),    32'(m_busy[k]));
      check($sformatf("lat%0d out_valid", lat_of(k)),  32'(ov[k]),     32'(e_ov[k]));
      check($sformatf("lat%0d out_code", lat_of(k)),   oc[k],          m_code[k]);
      check($sformatf("lat%0d out_id", lat_of(k)),     32'(oid[k]),    32'(m_id[k]));
      check($sformatf("lat%0d enc_data", lat_of(k)),   32'(ed[k]),     32'(m_data[k]));
      if ((r0_rdy[k] && req0_valid) || (r1_rdy[k] && req1_valid)) acc_seen[k] = cyc;
      if (ov[k] && !ov_prev[k]) begin
        check($sformatf("lat%0d latency", lat_of(k)), 32'(cyc - acc_seen[k]), 32'(lat_of(k) + 1));
        if (k == 0) id_log.push_back(oid[0]);
      end
      ov_prev[k] = ov[k];
    end
    @(posedge clock);
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        m_busy[k] = 1'b0;
        m_data[k] = '0;
        m_id[k]   = 1'b0;
        m_code[k] = '0;
        m_last[k] = 1'b1;
      end else if (!m_busy[k]) begin
        if (e_r0[k]) begin
          m_busy[k] = 1'b1; m_acc[k] = cyc; m_data[k] = req0_data;
          m_id[k]   = 1'b0; m_last[k] = 1'b0;
        end else if (e_r1[k]) begin
          m_busy[k] = 1'b1; m_acc[k] = cyc; m_data[k] = req1_data;
          m_id[k]   = 1'b1; m_last[k] = 1'b1;
        end
      end else if (e_ov[k] && out_ready) begin
        m_busy[k] = 1'b0;
      end
    end
    cyc++;
    for (int k = 0; k < 3; k++) begin
      if (m_busy[k] && (cyc == m_acc[k] + lat_of(k) + 1)) m_code[k] = ham(m_data[k]);
    end
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_busy[k] = 1'b0; m_acc[k] = 0; m_data[k] = '0; m_id[k] = 1'b0;
      m_code[k] = '0;   m_last[k] = 1'b1; acc_seen[k] = 0; ov_prev[k] = 1'b0;
    end
    reset      = 1'b1;
    req0_valid = 1'b0;
    req0_data  = '0;
    req1_valid = 1'b0;
    req1_data  = '0;
    out_ready  = 1'b0;

    // Reset state, with both requesters valid to show ready stays low.
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    ticks(2);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    reset      = 1'b0;

    // Single request from requester 0.
    req0_valid = 1'b1;
    req0_data  = 26'h1B1D535;
    out_ready  = 1'b1;
    tick();
    req0_valid = 1'b0;
    req0_data  = 26'h0;
    check("single enc_data T+1", 32'(ed[0]), 32'(26'h1B1D535));
    tick();
    check("single out_valid T+2", 32'(ov[0]), 32'd1);
    check("single out_code T+2", oc[0], ham(26'h1B1D535));
    check("single out_id T+2", 32'(oid[0]), 32'd0);
    ticks(6);

    // Tie straight after reset, then sustained contention.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    id_log.delete();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      req0_data = 26'($urandom);
      req1_data = 26'($urandom);
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    ticks(8);
    check("contention result count", 32'(id_log.size() >= 8), 32'd1);
    for (int i = 0; i < 8 && i < id_log.size(); i++) begin
      check($sformatf("contention out_id[%0d]", i), 32'(id_log[i]), 32'(i % 2));
    end

    // Backpressure: results held in HOLD while out_ready is low.
    out_ready  = 1'b0;
    req1_valid = 1'b1;
    req1_data  = 26'h2A5A5A5;
    tick();
    req0_valid = 1'b1;
    req0_data  = 26'h0F0F0F0;
    ticks(12);
    out_ready  = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    ticks(3);

    // Reset in the second ENCODE cycle of the ENC_LAT=4 copy.
    req0_valid = 1'b1;
    req0_data  = 26'h3FFFFFF;
    tick();
    req0_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset mid-encode busy", 32'(bsy[2]), 32'd0);
    check("reset mid-encode out_valid", 32'(ov[2]), 32'd0);
    ticks(8);

    // Randomised traffic with occasional resets and backpressure.
    for (int i = 0; i < 400; i++) begin
      reset      = ($urandom_range(0, 49) == 0);
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 3) != 0);
      req0_data  = 26'($urandom);
      req1_data  = 26'($urandom);
      out_ready  = ($urandom_range(0, 3) != 0);
      tick();
    end
    reset = 1'b0;
    ticks(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
